// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/mem/writeback and counts retired instructions.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  localparam logic [1:0] PC_ALU   = 2'b00;
  localparam logic [1:0] PC_OUT   = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;

endpackage

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_t state;
  state_t nxt;
  ctrl_t  c;
  logic   retire;

  logic is_mem;
  logic is_r;
  logic is_beq;
  logic is_addi;
  logic is_j;

  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_RTYPE);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);

  always_comb begin
    c      = '0;
    nxt    = S_FETCH;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        c.alusrcb = SRCB_4;
        c.irwrite = mem_ready;
        c.pcen    = mem_ready;
        nxt       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_BR;
        unique case (1'b1)
          is_mem:  nxt = S_MEMADR;
          is_r:    nxt = S_EXECUTE;
          is_beq:  nxt = S_BRANCH;
          is_addi: nxt = S_ADDIEX;
          is_j:    nxt = S_JUMP;
          default: begin
            c.illegal = 1'b1;
            nxt       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        nxt       = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
        nxt    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        retire     = mem_ready;
        nxt        = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALU_FN;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_SUB;
        c.pcsrc   = PC_OUT;
        c.pcen    = zero;
        retire    = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        nxt       = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        retire     = 1'b1;
      end
      S_JUMP: begin
        c.pcsrc = PC_JMP;
        c.pcen  = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
    // Strobes must drop the moment reset rises, without waiting for a clock.
    if (reset) begin
      c.irwrite  = 1'b0;
      c.memwrite = 1'b0;
      c.regwrite = 1'b0;
      c.pcen     = 1'b0;
      c.illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign iord     = c.iord;
  assign memwrite = c.memwrite;
  assign irwrite  = c.irwrite;
  assign regdst   = c.regdst;
  assign memtoreg = c.memtoreg;
  assign regwrite = c.regwrite;
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign aluop    = c.aluop;
  assign pcsrc    = c.pcsrc;
  assign pcen     = c.pcen;
  assign illegal  = c.illegal;
  assign state_o  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-path model.
// A second instance with CNT_W=2 shares stimulus to exercise counter wrap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state_o;
  logic [15:0] retired;

  logic       s_iord, s_memwrite, s_irwrite, s_regdst, s_memtoreg;
  logic       s_regwrite, s_alusrca, s_pcen, s_illegal;
  logic [1:0] s_alusrcb, s_aluop, s_pcsrc;
  logic [3:0] s_state_o;
  logic [1:0] s_retired;

  multicycle_ctrl u_dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal),
    .state_o(state_o), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .mem_ready(mem_ready),
    .iord(s_iord), .memwrite(s_memwrite), .irwrite(s_irwrite),
    .regdst(s_regdst), .memtoreg(s_memtoreg), .regwrite(s_regwrite),
    .alusrca(s_alusrca), .alusrcb(s_alusrcb), .aluop(s_aluop),
    .pcsrc(s_pcsrc), .pcen(s_pcen), .illegal(s_illegal),
    .state_o(s_state_o), .retired(s_retired)
  );

  always #5 clk = ~clk;

  wire [14:0] act = {iord, memwrite, irwrite, regdst, memtoreg,
                     regwrite, alusrca, alusrcb, aluop, pcsrc,
                     pcen, illegal};

  int ntests = 0;
  int nfail  = 0;

  // instruction-level model: the list of states an instruction visits
  int          path [8];
  int          plen;
  int          idx;
  bit          plegal;
  logic [31:0] cnt;
  bit          rdyq [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};
  endfunction

  function automatic logic [14:0] exp_ctrl(input int s,
      input logic [5:0] o, input logic z, input logic r);
    logic iord_e, mw, irw, rd, m2r, rw, asa, pen, ill;
    logic [1:0] asb, aop, psrc;
    {iord_e, mw, irw, rd, m2r, rw, asa, pen, ill} = '0;
    {asb, aop, psrc} = '0;
    case (s)
      0:  begin asb = 2'b01; irw = r; pen = r; end
      1:  begin asb = 2'b11; ill = !legal(o); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord_e = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord_e = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pen = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin psrc = 2'b10; pen = 1; end
      default: ;
    endcase
    return {iord_e, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pen, ill};
  endfunction

  task automatic build_path(input logic [5:0] o);
    path[0] = 0;
    path[1] = 1;
    plen    = 2;
    plegal  = 1;
    idx     = 0;
    case (o)
      6'h23: begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
      6'h2b: begin path[2] = 2; path[3] = 5; plen = 4; end
      6'h00: begin path[2] = 6; path[3] = 7; plen = 4; end
      6'h04: begin path[2] = 8; plen = 3; end
      6'h08: begin path[2] = 9; path[3] = 10; plen = 4; end
      6'h02: begin path[2] = 11; plen = 3; end
      default: plegal = 0;
    endcase
  endtask

  // called at posedge+1; checks at the falling edge, advances the model at
  // the next rising edge
  task automatic step(input logic [5:0] o, input logic z, input logic r);
    int s;
    s = path[idx];
    op = o;
    zero = z;
    mem_ready = r;
    #4;
    check("state", 32'(state_o), 32'(s));
    check("ctrl", 32'(act), 32'(exp_ctrl(s, o, z, r)));
    check("retired", 32'(retired), cnt & 32'hffff);
    check("s_retired", 32'(s_retired), cnt & 32'h3);
    check("s_state", 32'(s_state_o), 32'(s));
    @(posedge clk);
    if (!((s == 0 || s == 3 || s == 5) && !r))
      idx++;
    if (idx == plen && plegal)
      cnt++;
    #1;
  endtask

  // zmode: 0/1 holds zero fixed, 2 randomizes it per cycle
  task automatic run_instr(input logic [5:0] o, input int zmode);
    logic r, z;
    int budget;
    build_path(o);
    budget = 0;
    while (idx < plen) begin
      if (rdyq.size() != 0) r = rdyq.pop_front();
      else r = ($urandom_range(0, 3) != 0);
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      step(o, z, r);
      budget++;
      if (budget > 60) begin
        check("budget", 32'(budget), 32'(60));
        break;
      end
    end
  endtask

  logic [5:0] ops [6];
  logic [1:0] wrap_exp [5];

  initial begin
    ops[0] = 6'h23; ops[1] = 6'h2b; ops[2] = 6'h00;
    ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    cnt = 0;

    reset = 1'b1;
    op = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b1;
    #12;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_pcen", 32'(pcen), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    rdyq = '{1, 1, 1, 1};
    run_instr(6'h00, 0);
    rdyq = '{1, 1, 1, 0, 0, 1};
    run_instr(6'h23, 0);
    rdyq = '{1, 1, 1};
    run_instr(6'h04, 1);
    rdyq = '{1, 1, 1};
    run_instr(6'h04, 0);
    rdyq = '{1, 1, 1, 0, 0, 0, 1};
    run_instr(6'h2b, 0);
    rdyq = '{1, 1};
    run_instr(6'h3f, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        run_instr(6'($urandom_range(0, 63)), 2);
      else
        run_instr(ops[$urandom_range(0, 5)], 2);
    end

    // abort a store while it is waiting on memory
    build_path(6'h2b);
    step(6'h2b, 0, 1);
    step(6'h2b, 0, 1);
    step(6'h2b, 0, 1);
    mem_ready = 1'b0;
    #2;
    check("memwr_pre", 32'(memwrite), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_memwrite", 32'(memwrite), 32'd0);
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    check("abort_s_retired", 32'(s_retired), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;

    for (int i = 0; i < 5; i++) begin
      rdyq = '{1, 1, 1};
      run_instr(6'h02, 0);
      check("wrap", 32'(s_retired), 32'(wrap_exp[i]));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
